// File: rtl/vs_regfile_write_arbiter.sv
// Write-port arbiter for the vertex shader register file: req 0 has fixed priority,
// the remaining requesters rotate round-robin, and a starvation guard forces the pool through.
module vs_regfile_write_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 128,
  parameter int MASK_WIDTH   = 4,
  parameter int STARVE_LIMIT = 4,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            iReqValid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] iReqAddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] iReqData,
  input  logic [NUM_REQ*MASK_WIDTH-1:0] iReqMask,
  output logic [NUM_REQ-1:0]            oReqReady,
  input  logic                          iRfBusy,
  output logic                          oWrEnable,
  output logic [ADDR_WIDTH-1:0]         oWrAddr,
  output logic [DATA_WIDTH-1:0]         oWrData,
  output logic [MASK_WIDTH-1:0]         oWrMask,
  output logic [ID_W-1:0]               oGrantId,
  output logic                          oIdle
);

  typedef enum logic {ST_NORMAL, ST_FAIR} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [MASK_WIDTH-1:0] wr_mask_q, wr_mask_d;
  logic [ID_W-1:0]       wr_id_q, wr_id_d;

  logic                  pool_any;
  logic                  pool_hit;
  logic [ID_W-1:0]       pool_idx;
  logic [ID_W-1:0]       cand_id;
  int                    cand;
  logic                  gnt_vld;
  logic [ID_W-1:0]       gnt_id;
  logic [MASK_WIDTH-1:0] gnt_mask;

  // Pool scan starts at rr_ptr_q and wraps from NUM_REQ-1 back to 1, never touching req 0.
  always_comb begin
    pool_any = |iReqValid[NUM_REQ-1:1];
    pool_hit = 1'b0;
    pool_idx = '0;
    cand     = 0;
    cand_id  = '0;
    for (int off = 0; off < NUM_REQ - 1; off++) begin
      cand = int'(rr_ptr_q) + off;
      if (cand > NUM_REQ - 1) cand = cand - (NUM_REQ - 1);
      cand_id = ID_W'(cand);
      if (!pool_hit && iReqValid[cand_id]) begin
        pool_hit = 1'b1;
        pool_idx = cand_id;
      end
    end

    gnt_vld = 1'b0;
    gnt_id  = '0;
    if (!iRfBusy) begin
      if (state_q == ST_FAIR) begin
        if (pool_hit) begin
          gnt_vld = 1'b1;
          gnt_id  = pool_idx;
        end else if (iReqValid[0]) begin
          gnt_vld = 1'b1;
        end
      end else begin
        if (iReqValid[0]) begin
          gnt_vld = 1'b1;
        end else if (pool_hit) begin
          gnt_vld = 1'b1;
          gnt_id  = pool_idx;
        end
      end
    end
    oReqReady = gnt_vld ? (NUM_REQ'(1) << gnt_id) : '0;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    if (gnt_vld) begin
      if (gnt_id == '0) begin
        if (pool_any) begin
          if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else begin
          starve_cnt_d = '0;
        end
      end else begin
        starve_cnt_d = '0;
        state_d      = ST_NORMAL;
        rr_ptr_d     = (gnt_id == ID_W'(NUM_REQ - 1)) ? ID_W'(1) : gnt_id + ID_W'(1);
      end
      if (starve_cnt_d == CNT_W'(STARVE_LIMIT)) state_d = ST_FAIR;
    end else if (!iRfBusy && !pool_any) begin
      starve_cnt_d = '0;
    end
  end

  // Output register: a zero mask is still a handshake but must not strobe the register file.
  always_comb begin
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_mask_d = wr_mask_q;
    wr_id_d   = wr_id_q;
    gnt_mask  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_vld && gnt_id == ID_W'(i)) begin
        wr_addr_d = iReqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wr_data_d = iReqData[i*DATA_WIDTH +: DATA_WIDTH];
        wr_mask_d = iReqMask[i*MASK_WIDTH +: MASK_WIDTH];
        wr_id_d   = ID_W'(i);
        gnt_mask  = iReqMask[i*MASK_WIDTH +: MASK_WIDTH];
      end
    end
    wr_en_d = gnt_vld && (|gnt_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_NORMAL;
      rr_ptr_q     <= ID_W'(1);
      starve_cnt_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_mask_q    <= '0;
      wr_id_q      <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_mask_q    <= wr_mask_d;
      wr_id_q      <= wr_id_d;
    end
  end

  assign oWrEnable = wr_en_q;
  assign oWrAddr   = wr_addr_q;
  assign oWrData   = wr_data_q;
  assign oWrMask   = wr_mask_q;
  assign oGrantId  = wr_id_q;
  assign oIdle     = ~(|iReqValid) & ~wr_en_q;

endmodule

// File: tb/tb_vs_regfile_write_arbiter.sv
// Bench for vs_regfile_write_arbiter: directed vector table, reset corner sequence,
// then randomized traffic checked against a rule-level reference model.
module tb_vs_regfile_write_arbiter;
  localparam int NR = 3;
  localparam int AW = 8;
  localparam int DW = 128;
  localparam int MW = 4;
  localparam int LIMIT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    iReqValid;
  logic [NR*AW-1:0] iReqAddr;
  logic [NR*DW-1:0] iReqData;
  logic [NR*MW-1:0] iReqMask;
  logic [NR-1:0]    oReqReady;
  logic             iRfBusy;
  logic             oWrEnable;
  logic [AW-1:0]    oWrAddr;
  logic [DW-1:0]    oWrData;
  logic [MW-1:0]    oWrMask;
  logic [1:0]       oGrantId;
  logic             oIdle;

  vs_regfile_write_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .iReqValid(iReqValid), .iReqAddr(iReqAddr),
    .iReqData(iReqData), .iReqMask(iReqMask), .oReqReady(oReqReady), .iRfBusy(iRfBusy),
    .oWrEnable(oWrEnable), .oWrAddr(oWrAddr), .oWrData(oWrData), .oWrMask(oWrMask),
    .oGrantId(oGrantId), .oIdle(oIdle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] tab_addr(int i);
    return AW'(8'h10 * (i + 1));
  endfunction

  function automatic logic [DW-1:0] tab_data(int i);
    logic [31:0] w;
    w = 32'hA5A5_0000 | 32'(i);
    return {w, w, w, w};
  endfunction

  typedef struct {
    logic [NR-1:0] valid;
    logic          busy;
    logic [MW-1:0] mask;
    logic [NR-1:0] exp_ready;
    logic          exp_en;
    logic [1:0]    exp_id;
  } vec_t;

  vec_t vecs[21];

  // Reference model state
  int          m_ptr;
  int          m_cnt;
  bit          m_fair;
  bit          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [MW-1:0] m_mask;
  logic [1:0]    m_id;

  function automatic int model_pick(logic [NR-1:0] v, logic busy, bit fair, int ptr);
    int pool;
    int c;
    pool = -1;
    if (busy) return -1;
    for (int j = 0; j < NR - 1; j++) begin
      c = ((ptr - 1 + j) % (NR - 1)) + 1;
      if (pool < 0 && v[c]) pool = c;
    end
    if (fair) return (pool >= 0) ? pool : (v[0] ? 0 : -1);
    return v[0] ? 0 : pool;
  endfunction

  task automatic model_reset();
    m_ptr = 1; m_cnt = 0; m_fair = 0; m_en = 0;
    m_addr = '0; m_data = '0; m_mask = '0; m_id = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    iReqValid = '0;
    iRfBusy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drive_all(input logic [NR-1:0] v, input logic [MW-1:0] m);
    for (int i = 0; i < NR; i++) begin
      iReqAddr[i*AW +: AW] = tab_addr(i);
      iReqData[i*DW +: DW] = tab_data(i);
      iReqMask[i*MW +: MW] = m;
    end
    iReqValid = v;
  endtask

  bit            pend[NR];
  logic [AW-1:0] r_addr[NR];
  logic [DW-1:0] r_data[NR];
  logic [MW-1:0] r_mask[NR];

  initial begin
    int g;
    int rate;
    bit pool_any;
    logic [NR-1:0] exp_rdy;

    vecs[0]  = '{3'b010, 1'b0, 4'hF, 3'b010, 1'b1, 2'd1};
    vecs[1]  = '{3'b000, 1'b0, 4'hF, 3'b000, 1'b0, 2'd0};
    vecs[2]  = '{3'b110, 1'b0, 4'hF, 3'b100, 1'b1, 2'd2};
    vecs[3]  = '{3'b110, 1'b0, 4'hF, 3'b010, 1'b1, 2'd1};
    vecs[4]  = '{3'b010, 1'b1, 4'hF, 3'b000, 1'b0, 2'd0};
    vecs[5]  = '{3'b010, 1'b1, 4'hF, 3'b000, 1'b0, 2'd0};
    vecs[6]  = '{3'b010, 1'b1, 4'hF, 3'b000, 1'b0, 2'd0};
    vecs[7]  = '{3'b010, 1'b0, 4'hF, 3'b010, 1'b1, 2'd1};
    vecs[8]  = '{3'b100, 1'b0, 4'h0, 3'b100, 1'b0, 2'd0};
    vecs[9]  = '{3'b110, 1'b0, 4'hF, 3'b010, 1'b1, 2'd1};
    vecs[10] = '{3'b001, 1'b0, 4'h3, 3'b001, 1'b1, 2'd0};
    vecs[11] = '{3'b111, 1'b0, 4'hF, 3'b001, 1'b1, 2'd0};
    vecs[12] = '{3'b111, 1'b0, 4'hF, 3'b001, 1'b1, 2'd0};
    vecs[13] = '{3'b111, 1'b0, 4'hF, 3'b001, 1'b1, 2'd0};
    vecs[14] = '{3'b111, 1'b0, 4'hF, 3'b001, 1'b1, 2'd0};
    vecs[15] = '{3'b111, 1'b0, 4'hF, 3'b100, 1'b1, 2'd2};
    vecs[16] = '{3'b111, 1'b0, 4'hF, 3'b001, 1'b1, 2'd0};
    vecs[17] = '{3'b111, 1'b0, 4'hF, 3'b001, 1'b1, 2'd0};
    vecs[18] = '{3'b111, 1'b0, 4'hF, 3'b001, 1'b1, 2'd0};
    vecs[19] = '{3'b111, 1'b0, 4'hF, 3'b001, 1'b1, 2'd0};
    vecs[20] = '{3'b111, 1'b0, 4'hF, 3'b010, 1'b1, 2'd1};

    iReqAddr = '0; iReqData = '0; iReqMask = '0;
    do_reset();

    #1;
    chk("rst_en", 128'(oWrEnable), 128'(0));
    chk("rst_addr", 128'(oWrAddr), 128'(0));
    chk("rst_data", oWrData, 128'(0));
    chk("rst_mask", 128'(oWrMask), 128'(0));
    chk("rst_id", 128'(oGrantId), 128'(0));
    chk("rst_idle", 128'(oIdle), 128'(1));
    chk("rst_ready", 128'(oReqReady), 128'(0));

    // Directed vectors, one cycle each, starting from the reset state
    for (int k = 0; k < 21; k++) begin
      drive_all(vecs[k].valid, vecs[k].mask);
      iRfBusy = vecs[k].busy;
      #1;
      chk($sformatf("vec%0d_ready", k), 128'(oReqReady), 128'(vecs[k].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_en", k), 128'(oWrEnable), 128'(vecs[k].exp_en));
      if (vecs[k].exp_en) begin
        chk($sformatf("vec%0d_id", k), 128'(oGrantId), 128'(vecs[k].exp_id));
        chk($sformatf("vec%0d_addr", k), 128'(oWrAddr), 128'(tab_addr(int'(vecs[k].exp_id))));
        chk($sformatf("vec%0d_data", k), oWrData, tab_data(int'(vecs[k].exp_id)));
        chk($sformatf("vec%0d_mask", k), 128'(oWrMask), 128'(vecs[k].mask));
      end
    end

    // Reset landing right after a handshake drops the write accepted under reset
    do_reset();
    drive_all(3'b010, 4'hF);
    #1;
    chk("rs_ready", 128'(oReqReady), 128'(3'b010));
    @(posedge clk);
    #1;
    chk("rs_en_before", 128'(oWrEnable), 128'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rs_dropped", 128'(oWrEnable), 128'(0));
    reset = 1'b0;
    iReqValid = '0;
    #1;
    chk("rs_idle", 128'(oIdle), 128'(1));
    chk("rs_addr", 128'(oWrAddr), 128'(0));
    iReqValid = 3'b110;
    #1;
    chk("rs_ptr", 128'(oReqReady), 128'(3'b010));
    @(posedge clk);
    #1;

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < NR; i++) pend[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rate = ((cyc / 200) % 2 == 1) ? 95 : 50;
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && ($urandom % 100) < rate) begin
          pend[i] = 1;
          r_addr[i] = AW'($urandom);
          r_data[i] = {$urandom, $urandom, $urandom, $urandom};
          r_mask[i] = (($urandom % 8) == 0) ? '0 : MW'($urandom);
        end
        iReqValid[i] = pend[i];
        iReqAddr[i*AW +: AW] = r_addr[i];
        iReqData[i*DW +: DW] = r_data[i];
        iReqMask[i*MW +: MW] = r_mask[i];
      end
      iRfBusy = (($urandom % 4) == 0);
      #1;
      g = model_pick(iReqValid, iRfBusy, m_fair, m_ptr);
      exp_rdy = (g < 0) ? '0 : NR'(1 << g);
      chk("rnd_ready", 128'(oReqReady), 128'(exp_rdy));

      pool_any = |iReqValid[NR-1:1];
      if (!iRfBusy) begin
        if (g == 0) begin
          if (pool_any) begin
            if (m_cnt < LIMIT) m_cnt++;
            if (m_cnt == LIMIT) m_fair = 1;
          end else begin
            m_cnt = 0;
          end
        end else if (g > 0) begin
          m_cnt = 0;
          m_fair = 0;
          m_ptr = (g == NR - 1) ? 1 : g + 1;
        end else begin
          m_cnt = 0;
        end
      end
      if (g >= 0) begin
        m_en = |r_mask[g];
        m_addr = r_addr[g];
        m_data = r_data[g];
        m_mask = r_mask[g];
        m_id = 2'(g);
        pend[g] = 0;
      end else begin
        m_en = 0;
      end

      @(posedge clk);
      #1;
      chk("rnd_en", 128'(oWrEnable), 128'(m_en));
      chk("rnd_idle", 128'(oIdle), 128'((iReqValid == '0) && !m_en));
      if (m_en) begin
        chk("rnd_id", 128'(oGrantId), 128'(m_id));
        chk("rnd_addr", 128'(oWrAddr), 128'(m_addr));
        chk("rnd_data", oWrData, m_data);
        chk("rnd_mask", 128'(oWrMask), 128'(m_mask));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
